// File: rtl/mux_route_pkg.sv
// Shared constants and state encoding for the mux route arbiter.
package mux_route_pkg;

    localparam int NREQ              = 4;
    localparam int TO_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority pick: first set request scanning from ptr_i upward, modulo 4.
module rr_priority_picker
    import mux_route_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] win_onehot_o,
    output logic [1:0]      win_idx_o,
    output logic            valid_o
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_idx_o = '0;
        valid_o   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[2'(ptr_i + 2'(k))]) begin
                valid_o   = 1'b1;
                win_idx_o = 2'(ptr_i + 2'(k));
            end
        end
        win_onehot_o = valid_o ? (NREQ'(1) << win_idx_o) : '0;
    end

endmodule

// File: rtl/mux_route_arbiter.sv
// Rotating-priority arbiter sequencing the shared route mux through SETUP/ACTIVE/RELEASE.
// Optional ACTIVE watchdog enabled by defining MUX_ROUTE_TIMEOUT_EN.
module mux_route_arbiter
    import mux_route_pkg::*;
#(
    parameter int SIZE = 5
`ifdef MUX_ROUTE_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = TO_CYCLES_DEFAULT
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_code,
    input  logic                 done,
    output logic [NREQ-1:0]      grant,
    output logic [SIZE-1:0]      mux_res,
    output logic                 mux_en,
    output logic                 busy,
    output logic                 timeout
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SIZE-1:0] res_q, res_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      widx_q, widx_d;
    logic            act_exit;

    logic [NREQ-1:0] pick_onehot;
    logic [1:0]      pick_idx;
    logic            pick_valid;

`ifdef MUX_ROUTE_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    rr_priority_picker u_picker (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .win_onehot_o (pick_onehot),
        .win_idx_o    (pick_idx),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        res_d    = res_q;
        en_d     = en_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        widx_d   = widx_q;
        act_exit = 1'b0;
`ifdef MUX_ROUTE_TIMEOUT_EN
        cnt_d = cnt_q;
        to_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    grant_d = pick_onehot;
                    res_d   = req_code[int'(pick_idx)*SIZE +: SIZE];
                    busy_d  = 1'b1;
                    widx_d  = pick_idx;
                end
            end
            SETUP: begin
                state_d = ACTIVE;
                en_d    = 1'b1;
`ifdef MUX_ROUTE_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ACTIVE: begin
                // Completion and requester abort both outrank the watchdog.
                act_exit = done || !req[widx_q];
`ifdef MUX_ROUTE_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (!act_exit && cnt_q == CW'(TO_CYCLES - 1)) begin
                    act_exit = 1'b1;
                    to_d     = 1'b1;
                end
`endif
                if (act_exit) begin
                    state_d = RELEASE;
                    en_d    = 1'b0;
                    grant_d = '0;
                    res_d   = '0;
                    ptr_d   = widx_q + 2'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            res_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            res_q   <= res_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
        end
    end

`ifdef MUX_ROUTE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant   = grant_q;
    assign mux_res = res_q;
    assign mux_en  = en_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mux_route_arbiter.sv
// Scoreboard bench for mux_route_arbiter: expected grant/code queued at request, checked at SETUP.
module tb_mux_route_arbiter;

    localparam int SIZE = 5;
`ifdef MUX_ROUTE_TIMEOUT_EN
    localparam int TO_CYCLES = 16;
`endif

    typedef struct packed {
        logic [3:0]      grant;
        logic [SIZE-1:0] code;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [4*SIZE-1:0] req_code;
    logic              done;
    logic [3:0]        grant;
    logic [SIZE-1:0]   mux_res;
    logic              mux_en;
    logic              busy;
    logic              timeout;

    int   vectors     = 0;
    int   miscompares = 0;
    int   model_ptr   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mux_route_arbiter #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_code (req_code),
        .done     (done),
        .grant    (grant),
        .mux_res  (mux_res),
        .mux_en   (mux_en),
        .busy     (busy),
        .timeout  (timeout)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_codes(input logic [SIZE-1:0] c0, input logic [SIZE-1:0] c1,
                             input logic [SIZE-1:0] c2, input logic [SIZE-1:0] c3);
        req_code = {c3, c2, c1, c0};
    endtask

    // One full transaction: grant, n_active ACTIVE cycles, RELEASE, IDLE.
    task automatic do_txn(input logic [3:0] r, input int n_active, input bit abort,
                          input bit mutate, input bit exp_to, input string tag,
                          output logic [3:0] g_seen);
        int   w;
        exp_t e;
        w       = pick(r, model_ptr);
        e.grant = 4'(1 << w);
        e.code  = req_code[w*SIZE +: SIZE];
        sb.push_back(e);
        req = r;
        tick();
        g_seen = grant;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty at grant=%b", tag, grant);
        end else begin
            e = sb.pop_front();
            if ({grant, mux_res, mux_en, busy} !== {e.grant, e.code, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL %s setup: grant=%b res=%0d en=%b busy=%b, want grant=%b res=%0d en=0 busy=1",
                         tag, grant, mux_res, mux_en, busy, e.grant, e.code);
            end
        end
        tick();
        for (int i = 1; i <= n_active; i++) begin
            vectors++;
            if ({grant, mux_res, mux_en, timeout} !== {e.grant, e.code, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL %s active cycle %0d: grant=%b res=%0d en=%b to=%b, want grant=%b res=%0d en=1 to=0",
                         tag, i, grant, mux_res, mux_en, timeout, e.grant, e.code);
            end
            if (mutate && i == 1) req_code[w*SIZE +: SIZE] = e.code + SIZE'(2);
            if (i == n_active && !exp_to) begin
                if (abort) req[w] = 1'b0;
                else       done   = 1'b1;
            end
            tick();
        end
        done = 1'b0;
        vectors++;
        if ({grant, mux_res, mux_en, busy, timeout} !== {4'b0, SIZE'(0), 1'b0, 1'b1, exp_to}) begin
            miscompares++;
            $display("FAIL %s release: grant=%b res=%0d en=%b busy=%b to=%b, want 0000/0/0/1/%b",
                     tag, grant, mux_res, mux_en, busy, timeout, exp_to);
        end
        model_ptr = (w + 1) % 4;
        tick();
        vectors++;
        if ({grant, mux_en, busy, timeout} !== 7'b0) begin
            miscompares++;
            $display("FAIL %s idle: grant=%b en=%b busy=%b to=%b, want all 0",
                     tag, grant, mux_en, busy, timeout);
        end
        req = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        set_codes(5'd0, 5'd0, 5'd0, 5'd0);
        #12;
        vectors++;
        if ({grant, mux_res, mux_en, busy, timeout} !== '0) begin
            miscompares++;
            $display("FAIL reset: grant=%b res=%0d en=%b busy=%b to=%b, want all 0",
                     grant, mux_res, mux_en, busy, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if ({grant, mux_en, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: grant=%b en=%b busy=%b, want all 0", grant, mux_en, busy);
        end
        model_ptr = 0;
    endtask

    task automatic test_single();
        logic [3:0] g;
        set_codes(5'd7, 5'd3, 5'd9, 5'd12);
        do_txn(4'b0010, 3, 1'b0, 1'b0, 1'b0, "single", g);
    endtask

    task automatic test_abort();
        logic [3:0] g;
        set_codes(5'd4, 5'd5, 5'd6, 5'd8);
        do_txn(4'b1101, 2, 1'b1, 1'b0, 1'b0, "abort", g);
    endtask

    task automatic test_code_hold();
        logic [3:0] g;
        set_codes(5'd1, 5'd17, 5'd18, 5'd19);
        do_txn(4'b0111, 4, 1'b0, 1'b1, 1'b0, "code_hold", g);
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   w;
        set_codes(5'd21, 5'd22, 5'd23, 5'd24);
        w       = pick(4'b0101, model_ptr);
        e.grant = 4'(1 << w);
        e.code  = req_code[w*SIZE +: SIZE];
        sb.push_back(e);
        req = 4'b0101;
        tick();
        vectors++;
        e = sb.pop_front();
        if ({grant, mux_res} !== {e.grant, e.code}) begin
            miscompares++;
            $display("FAIL async_pre grant: grant=%b res=%0d, want grant=%b res=%0d",
                     grant, mux_res, e.grant, e.code);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({grant, mux_res, mux_en, busy} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: grant=%b res=%0d en=%b busy=%b, want all 0",
                     grant, mux_res, mux_en, busy);
        end
        req = '0;
        tick();
        #3;
        rst_n     = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] g;
        set_codes(5'd11, 5'd12, 5'd13, 5'd14);
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 1, 1'b0, 1'b0, 1'b0, "round_robin", g);
            vectors++;
            if (g !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL rr_order %0d: grant=%b, want %b", i, g, exp_seq[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [3:0] g;
        set_codes(5'd2, 5'd30, 5'd2, 5'd2);
`ifdef MUX_ROUTE_TIMEOUT_EN
        do_txn(4'b0010, TO_CYCLES, 1'b0, 1'b0, 1'b1, "timeout", g);
`else
        do_txn(4'b0010, 110, 1'b0, 1'b0, 1'b0, "no_timeout", g);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_code_hold();
        test_async_reset();
        test_round_robin();
        test_watchdog();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_route_arbiter.md
Name: mux_route_arbiter

Overview:
- Sequencer and arbiter that shares the single 4-way result-routing multiplexer between four requesters.
- Each requester presents a SIZE-bit route code. The arbiter picks one requester by rotating priority, latches its code, and drives the multiplexer's code and enable inputs through a setup/active/release sequence.
- It holds the route until the downstream sink signals completion.
- Sits directly in front of the multiplexer in the datapath.

Parameters:
- SIZE, 5, width of the route code and of mux_res.
- NREQ, 4, number of requesters; fixed at 4, not a free parameter in this revision.
- TO_CYCLES, 16, ACTIVE-state watchdog limit in cycles; used only with TIMEOUT_EN.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; bit i = requester i; level-sensitive.
- req_code  input  4*SIZE  route codes, flat; requester i at [i*SIZE +: SIZE].
- done  input  1  sink completion strobe; sampled only in ACTIVE.
- grant  output  4  one-hot grant to the winning requester; 0 when none.
- mux_res  output  SIZE  latched route code to the multiplexer res input.
- mux_en  output  1  enable to the multiplexer.
- busy  output  1  high in every state except IDLE.
- timeout  output  1  one-cycle watchdog abort pulse; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - state=IDLE; grant=0, mux_res=0, mux_en=0, busy=0, timeout=0.
  - Rotating pointer ptr=0; watchdog count=0.
  - mux_en drops at once with no release cycle.
- State encoding is 2 bits: IDLE=0, SETUP=1, ACTIVE=2, RELEASE=3. All outputs are registered.
- IDLE:
  - If req!=0 at edge k, the winner w is the first set bit scanning ptr, ptr+1, ... modulo 4.
  - After edge k: grant=1<<w, mux_res=req_code[w], busy=1, state=SETUP.
  - If req==0, stay in IDLE.
- SETUP:
  - Exactly one cycle with mux_en=0 and the code stable, so downstream sees the code one cycle before the enable.
  - done is ignored here. Next state is ACTIVE.
- ACTIVE:
  - mux_en=1.
  - Exit to RELEASE when done=1, or when req[w]=0 (requester abort).
  - If done and the req[w] drop occur in the same cycle, treat it as normal completion.
  - Changes on req_code or on other req bits are ignored; the code stays latched.
- RELEASE:
  - One cycle: mux_en=0, grant=0, mux_res=0.
  - ptr=(w+1) mod 4 on every exit path (completion, abort, timeout).
  - Next state is IDLE.
- Latency and fairness:
  - req in IDLE at edge k gives grant after edge k and mux_en after edge k+1.
  - done at edge t gives mux_en=0 after edge t, and the next grant no earlier than edge t+2.
  - Any continuously asserting requester wins within 4 grants.
- A route code of 0 (or any value) is forwarded unfiltered. Decoding stays in the multiplexer.
- grant is never multi-hot. mux_en=1 only in ACTIVE.

Optional Feature:
- Macro: MUX_ROUTE_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width $clog2(TO_CYCLES+1) clears on SETUP->ACTIVE and increments each ACTIVE cycle without done.
  - When it reaches TO_CYCLES, go to RELEASE with timeout=1 during that RELEASE cycle only.
  - If done and timeout coincide, done wins and timeout stays 0.
- Not defined: no counter; timeout tied to 0; ACTIVE waits indefinitely.

Decomposition:
- Package mux_route_pkg holds:
  - state encoding constants IDLE/SETUP/ACTIVE/RELEASE;
  - NREQ=4;
  - the default TO_CYCLES.
- Sub-module rr_priority_picker: purely combinational. Takes req[3:0] and ptr[1:0] and returns a one-hot winner plus its 2-bit index. The arbiter FSM and datapath stay in mux_route_arbiter.

Test Plan:
- Reset, then req=4'b0010, req_code[1]=5'd3, done at 3rd ACTIVE cycle:
  - Expect grant=0010 and mux_res=3, with mux_en high the following cycle for exactly 3 cycles.
  - Then RELEASE clears all outputs, and ptr=2.
- req=4'b1111 held, done one cycle into each ACTIVE:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant is separated by SETUP/ACTIVE/RELEASE/IDLE; never multi-hot.
- Requester 2 granted, drop req[2] in the 2nd ACTIVE cycle with no done:
  - RELEASE next cycle, timeout=0, ptr=3.
- req_code[0] changed from 1 to 3 during ACTIVE:
  - mux_res stays 1 until RELEASE.
- Assert rst_n=0 asynchronously mid-ACTIVE:
  - mux_en, grant and busy go 0 before the next clock edge.
  - After release, the first grant goes to requester 0 (ptr=0).
- With MUX_ROUTE_TIMEOUT_EN, TO_CYCLES=16, no done:
  - mux_en high for 16 cycles, then timeout=1 for exactly one cycle.
- Without the macro: mux_en stays high past 100 cycles and timeout stays 0.
